// File: rtl/ddr3_read_checker_pkg.sv
// Shared types and constants for the DDR3 read-data checker.
// Command codes, status encodings and fail_cause bit positions.
package ddr3_read_checker_pkg;

  localparam int DW_DEF = 64;

  typedef enum logic [2:0] {
    CMD_NADA  = 3'd0,
    CMD_READ  = 3'd1,
    CMD_WRITE = 3'd2,
    CMD_ACT   = 3'd3,
    CMD_PRE   = 3'd4,
    CMD_REF   = 3'd5
  } ddr3_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_PASS = 2'b10,
    ST_FAIL = 2'b11
  } status_e;

  localparam int C_MIS = 0;
  localparam int C_ORP = 1;
  localparam int C_TMO = 2;
  localparam int C_WL  = 3;
  localparam int C_OVF = 4;

endpackage

// File: rtl/ddr3_read_checker_exp_fifo.sv
// Synchronous FIFO of expected words with flush, full/empty/count.
// Ports: push/din in, pop/dout out, full (registered), empty, count.
module ddr3_exp_fifo
  import ddr3_read_checker_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = full_q;
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    full_d = (count_d == FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ddr3_read_checker.sv
// Compares DDR3 read beats against queued expected words in order.
// Ports: exp push in, read beat in, wl_err in; counters, capture, cause, status out.
module ddr3_read_checker
  import ddr3_read_checker_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          exp_valid,
  input  logic [DW-1:0] exp_data,
  output logic          exp_ready,
  input  logic [DW-1:0] read_data,
  input  logic          read_data_valid,
  input  logic          wl_err,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] fail_cnt,
  output logic [DW-1:0] fail_data,
  output logic [DW-1:0] fail_exp,
  output logic [4:0]    fail_cause,
  output logic [1:0]    status
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_VAL = TW'(TIMEOUT);

  logic          full, empty;
  logic [DW-1:0] head;
  logic [$clog2(DEPTH):0] count;
  logic          push_acc, pop_acc;

  logic          cmp_valid_q, cmp_valid_d;
  logic          cmp_match_q, cmp_match_d;
  logic [DW-1:0] cmp_data_q, cmp_data_d;
  logic [DW-1:0] cmp_exp_q, cmp_exp_d;
  logic [CW-1:0] pass_cnt_q, pass_cnt_d;
  logic [CW-1:0] fail_cnt_q, fail_cnt_d;
  logic [DW-1:0] fail_data_q, fail_data_d;
  logic [DW-1:0] fail_exp_q, fail_exp_d;
  logic [4:0]    cause_q, cause_d;
  logic [TW-1:0] timer_q, timer_d;
  status_e       state_q, state_d;

  assign exp_ready = ~full;
  // Dropped/flushed traffic never reaches the FIFO during clear.
  assign push_acc  = exp_valid & ~full & ~clear;
  assign pop_acc   = read_data_valid & ~empty & ~clear;

  ddr3_exp_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clear),
    .push  (push_acc),
    .din   (exp_data),
    .pop   (pop_acc),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    cmp_valid_d = pop_acc;
    cmp_match_d = (head == read_data);
    cmp_data_d  = read_data;
    cmp_exp_d   = head;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    fail_data_d = fail_data_q;
    fail_exp_d  = fail_exp_q;
    cause_d     = cause_q;
    timer_d     = timer_q;

    if (cmp_valid_q && cmp_match_q) begin
      if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + 1'b1;
    end
    if (cmp_valid_q && !cmp_match_q) begin
      if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
      // A zero fail count means no mismatch captured yet.
      if (fail_cnt_q == '0) begin
        fail_data_d = cmp_data_q;
        fail_exp_d  = cmp_exp_q;
      end
      cause_d[C_MIS] = 1'b1;
    end

    if (empty || read_data_valid) timer_d = '0;
    else if (timer_q != TMO_VAL) timer_d = timer_q + 1'b1;

    if (timer_q == TMO_VAL)              cause_d[C_TMO] = 1'b1;
    if (read_data_valid && empty)        cause_d[C_ORP] = 1'b1;
    if (wl_err)                          cause_d[C_WL]  = 1'b1;
    if (exp_valid && full)               cause_d[C_OVF] = 1'b1;

    if (clear) begin
      cmp_valid_d = 1'b0;
      cmp_match_d = 1'b0;
      cmp_data_d  = '0;
      cmp_exp_d   = '0;
      pass_cnt_d  = '0;
      fail_cnt_d  = '0;
      fail_data_d = '0;
      fail_exp_d  = '0;
      cause_d     = '0;
      timer_d     = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (push_acc) state_d = ST_RUN;
      ST_RUN: begin
        if (empty && !cmp_valid_q && cause_q == '0 && !push_acc)
          state_d = ST_PASS;
      end
      ST_PASS: if (push_acc) state_d = ST_RUN;
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_IDLE;
    endcase
    if (cause_q != '0) state_d = ST_FAIL;
    if (clear)         state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_valid_q <= 1'b0;
      cmp_match_q <= 1'b0;
      cmp_data_q  <= '0;
      cmp_exp_q   <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      fail_data_q <= '0;
      fail_exp_q  <= '0;
      cause_q     <= '0;
      timer_q     <= '0;
      state_q     <= ST_IDLE;
    end else begin
      cmp_valid_q <= cmp_valid_d;
      cmp_match_q <= cmp_match_d;
      cmp_data_q  <= cmp_data_d;
      cmp_exp_q   <= cmp_exp_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_data_q <= fail_data_d;
      fail_exp_q  <= fail_exp_d;
      cause_q     <= cause_d;
      timer_q     <= timer_d;
      state_q     <= state_d;
    end
  end

  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;
  assign fail_data  = fail_data_q;
  assign fail_exp   = fail_exp_q;
  assign fail_cause = cause_q;
  assign status     = state_q;

  logic unused_ok;
  assign unused_ok = ^count;

endmodule

// File: tb/tb_ddr3_read_checker.sv
// Directed self-checking bench for ddr3_read_checker.
// Drives inputs on negedge and samples outputs on negedge.
module tb_ddr3_read_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        exp_valid;
  logic [63:0] exp_data;
  logic        exp_ready;
  logic [63:0] read_data;
  logic        read_data_valid;
  logic        wl_err;
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;
  logic [63:0] fail_data;
  logic [63:0] fail_exp;
  logic [4:0]  fail_cause;
  logic [1:0]  status;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ddr3_read_checker #(
    .DW(64), .DEPTH(8), .TIMEOUT(16), .CW(16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .exp_valid       (exp_valid),
    .exp_data        (exp_data),
    .exp_ready       (exp_ready),
    .read_data       (read_data),
    .read_data_valid (read_data_valid),
    .wl_err          (wl_err),
    .pass_cnt        (pass_cnt),
    .fail_cnt        (fail_cnt),
    .fail_data       (fail_data),
    .fail_exp        (fail_exp),
    .fail_cause      (fail_cause),
    .status          (status)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [63:0] d);
    exp_valid = 1'b1;
    exp_data  = d;
    @(negedge clk);
    exp_valid = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d);
    read_data_valid = 1'b1;
    read_data       = d;
    @(negedge clk);
    read_data_valid = 1'b0;
  endtask

  task automatic push_beat(input logic [63:0] d);
    exp_valid       = 1'b1;
    exp_data        = d;
    read_data_valid = 1'b1;
    read_data       = d;
    @(negedge clk);
    exp_valid       = 1'b0;
    read_data_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    exp_valid = 1'b0;
    exp_data = '0;
    read_data = '0;
    read_data_valid = 1'b0;
    wl_err = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);

    chk("rst_pass", 64'(pass_cnt), 64'd0);
    chk("rst_fail", 64'(fail_cnt), 64'd0);
    chk("rst_cause", 64'(fail_cause), 64'd0);
    chk("rst_ready", 64'(exp_ready), 64'd1);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_fdata", fail_data, 64'd0);

    // single matching beat
    push(64'h0123456789ABCDEF);
    chk("t1_run", 64'(status), 64'd1);
    beat(64'h0123456789ABCDEF);
    idle(3);
    chk("t1_pass", 64'(pass_cnt), 64'd1);
    chk("t1_fail", 64'(fail_cnt), 64'd0);
    chk("t1_status", 64'(status), 64'd2);

    // mismatch with first-capture
    do_clear();
    push(64'hDEADBEEFAAAA5555);
    beat(64'hDEADBEEFAAAA5554);
    idle(3);
    chk("t2_fail", 64'(fail_cnt), 64'd1);
    chk("t2_fdata", fail_data, 64'hDEADBEEFAAAA5554);
    chk("t2_fexp", fail_exp, 64'hDEADBEEFAAAA5555);
    chk("t2_cause", 64'(fail_cause), 64'h01);
    chk("t2_status", 64'(status), 64'd3);
    push(64'h1111);
    beat(64'h2222);
    idle(3);
    chk("t2_fail2", 64'(fail_cnt), 64'd2);
    chk("t2_keep", fail_data, 64'hDEADBEEFAAAA5554);

    // fill, overflow, drain
    do_clear();
    for (int i = 0; i < 8; i++) push(64'h1000 + 64'(i));
    chk("t3_full", 64'(exp_ready), 64'd0);
    chk("t3_nocause", 64'(fail_cause), 64'd0);
    push(64'hBAD);
    chk("t3_ovf", 64'(fail_cause), 64'h10);
    for (int i = 0; i < 8; i++) beat(64'h1000 + 64'(i));
    idle(3);
    chk("t3_pass", 64'(pass_cnt), 64'd8);
    chk("t3_fail", 64'(fail_cnt), 64'd0);
    chk("t3_ready", 64'(exp_ready), 64'd1);
    chk("t3_status", 64'(status), 64'd3);

    // orphan beats
    do_clear();
    beat(64'h55);
    idle(2);
    chk("t4_orph", 64'(fail_cause), 64'h02);
    chk("t4_pass", 64'(pass_cnt), 64'd0);
    chk("t4_fail", 64'(fail_cnt), 64'd0);
    do_clear();
    push_beat(64'h77);
    idle(1);
    chk("t4_orph2", 64'(fail_cause), 64'h02);
    beat(64'h77);
    idle(3);
    chk("t4_kept", 64'(pass_cnt), 64'd1);

    // timeout
    do_clear();
    push(64'h99);
    idle(10);
    chk("t5_early", 64'(fail_cause), 64'h00);
    idle(10);
    chk("t5_tmo", 64'(fail_cause), 64'h04);
    chk("t5_status", 64'(status), 64'd3);
    beat(64'h99);
    idle(3);
    chk("t5_intact", 64'(pass_cnt), 64'd1);
    do_clear();
    idle(1);
    chk("t5_clr_p", 64'(pass_cnt), 64'd0);
    chk("t5_clr_c", 64'(fail_cause), 64'd0);
    chk("t5_clr_s", 64'(status), 64'd0);
    chk("t5_clr_r", 64'(exp_ready), 64'd1);

    // wl_err
    push(64'hABC);
    wl_err = 1'b1;
    idle(1);
    wl_err = 1'b0;
    idle(2);
    chk("t6_wl", 64'(fail_cause), 64'h08);
    chk("t6_status", 64'(status), 64'd3);
    beat(64'hABC);
    idle(3);
    chk("t6_pass", 64'(pass_cnt), 64'd1);
    chk("t6_sticky", 64'(status), 64'd3);

    // beat coinciding with clear / rst
    do_clear();
    push(64'h42);
    idle(1);
    clear = 1'b1;
    read_data_valid = 1'b1;
    read_data = 64'h42;
    idle(1);
    clear = 1'b0;
    read_data_valid = 1'b0;
    idle(3);
    chk("t7_clr_p", 64'(pass_cnt), 64'd0);
    chk("t7_clr_c", 64'(fail_cause), 64'd0);
    chk("t7_clr_s", 64'(status), 64'd0);
    push(64'h43);
    idle(1);
    rst = 1'b1;
    read_data_valid = 1'b1;
    read_data = 64'h43;
    idle(1);
    rst = 1'b0;
    read_data_valid = 1'b0;
    idle(3);
    chk("t7_rst_p", 64'(pass_cnt), 64'd0);
    chk("t7_rst_f", 64'(fail_cnt), 64'd0);
    chk("t7_rst_s", 64'(status), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
